// File: rtl/gen_scan_pkg.sv
// gen_scan_pkg: shared encodings for the scan generator.
//   scan_mode_e  : waveform selected by scan_mode (triangle, saw up, saw down, hold)
//   scan_state_e : sequencing states of the generator (idle, running, done)
package gen_scan_pkg;

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW_UP = 2'd1,
    MODE_SAW_DN = 2'd2,
    MODE_HOLD   = 2'd3
  } scan_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/gen_scan_mult.sv
// gen_scan_mult: registered signed multiply followed by arithmetic shift.
//   clk, rst : clock and synchronous active-high reset
//   a, b     : signed R-bit operands
//   p        : ((a*b) as 2R bits) >>> BS, truncated to R bits; 2-cycle latency
module gen_scan_mult #(
  parameter int R  = 14,
  parameter int BS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [R-1:0] a,
  input  logic signed [R-1:0] b,
  output logic signed [R-1:0] p
);

  logic signed [2*R-1:0] a_x;
  logic signed [2*R-1:0] b_x;
  logic signed [2*R-1:0] prod;
  logic signed [2*R-1:0] prod_sh;

  // Sign-extend explicitly so the low 2R bits of the product are exact.
  assign a_x     = {{R{a[R-1]}}, a};
  assign b_x     = {{R{b[R-1]}}, b};
  assign prod_sh = prod >>> BS;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      p    <= '0;
    end else begin
      prod <= a_x * b_x;
      p    <= prod_sh[R-1:0];
    end
  end

endmodule

// File: rtl/gen_scan.sv
// gen_scan: scan waveform generator (triangle / saw up / saw down / hold).
//   clk, rst          : clock and synchronous active-high reset
//   scan_step         : dwell, a tick every scan_step+1 enabled cycles
//   scan_inc          : unsigned step per tick (0 behaves as 1)
//   scan_low_lim/hig  : signed limits of outA
//   scan_B_factor     : signed gain applied to outA to form outB
//   scan_mode         : waveform select, see gen_scan_pkg::scan_mode_e
//   scan_enable       : run when high, freeze when low
//   scan_reset        : synchronous restart, overrides all other inputs
//   scan_cycles       : number of periods to run, 0 = unlimited
//   outA, outB        : scan value and scaled copy (2 cycles behind outA)
//   trigger_low/hig   : one-cycle pulse when outA arrives at a limit
//   direction_out     : 1 while the slope is rising
//   done              : high once scan_cycles periods have completed
module gen_scan
  import gen_scan_pkg::*;
#(
  parameter int R  = 14,
  parameter int CW = 32,
  parameter int BS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       scan_step,
  input  logic [R-2:0]        scan_inc,
  input  logic signed [R-1:0] scan_low_lim,
  input  logic signed [R-1:0] scan_hig_lim,
  input  logic signed [R-1:0] scan_B_factor,
  input  logic [1:0]          scan_mode,
  input  logic                scan_enable,
  input  logic                scan_reset,
  input  logic [15:0]         scan_cycles,
  output logic signed [R-1:0] outA,
  output logic signed [R-1:0] outB,
  output logic                trigger_low,
  output logic                trigger_hig,
  output logic                direction_out,
  output logic                done
);

  scan_state_e   state;
  scan_mode_e    mode;
  logic [CW-1:0] dwell_cnt;
  logic [CW-1:0] step_prev;
  logic [15:0]   period_cnt;

  // Next-value arithmetic is one bit wider than outA so a+inc never wraps.
  logic signed [R:0] lo_x, hi_x, a_x, inc_x, sum_x, dif_x, nxt_x;
  logic [R-2:0]      inc_eff;
  logic              limits_ok, nxt_dir, period_end, step_changed, tick, last_period;

  assign mode         = scan_mode_e'(scan_mode);
  assign inc_eff      = (scan_inc == '0) ? (R-1)'(1) : scan_inc;
  assign lo_x         = {scan_low_lim[R-1], scan_low_lim};
  assign hi_x         = {scan_hig_lim[R-1], scan_hig_lim};
  assign a_x          = {outA[R-1], outA};
  assign inc_x        = {2'b00, inc_eff};
  assign sum_x        = a_x + inc_x;
  assign dif_x        = a_x - inc_x;
  assign limits_ok    = lo_x < hi_x;
  assign step_changed = scan_step != step_prev;
  assign tick         = (state == ST_RUN) && scan_enable && !step_changed &&
                        (dwell_cnt == scan_step);
  assign last_period  = (scan_cycles != '0) &&
                        (({1'b0, period_cnt} + 17'd1) >= {1'b0, scan_cycles});

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_x      = a_x;
    nxt_dir    = direction_out;
    period_end = 1'b0;
    if (!limits_ok) begin
      nxt_x = lo_x;
    end else if (a_x < lo_x) begin
      nxt_x = lo_x;
    end else if (a_x > hi_x) begin
      nxt_x = hi_x;
    end else begin
      case (mode)
        MODE_TRI: begin
          if (direction_out) begin
            if (sum_x >= hi_x) begin
              nxt_x   = hi_x;
              nxt_dir = 1'b0;
            end else begin
              nxt_x = sum_x;
            end
          end else begin
            if (dif_x <= lo_x) begin
              nxt_x      = lo_x;
              nxt_dir    = 1'b1;
              // Turning round while already parked at low is not an arrival.
              period_end = (a_x != lo_x);
            end else begin
              nxt_x = dif_x;
            end
          end
        end
        MODE_SAW_UP: begin
          nxt_dir = 1'b1;
          if (a_x == hi_x) begin
            nxt_x      = lo_x;
            period_end = 1'b1;
          end else if (sum_x >= hi_x) begin
            nxt_x = hi_x;
          end else begin
            nxt_x = sum_x;
          end
        end
        MODE_SAW_DN: begin
          nxt_dir = 1'b0;
          if (a_x == lo_x) begin
            nxt_x      = hi_x;
            period_end = 1'b1;
          end else if (dif_x <= lo_x) begin
            nxt_x = lo_x;
          end else begin
            nxt_x = dif_x;
          end
        end
        default: ;  // hold: keep value and slope
      endcase
    end
  end

  // NOTE: step_prev only remembers the last scan_step to spot a change; it
  // follows the input every cycle, including during reset, so it needs no reset
  // value and never produces a spurious change after reset.
  always_ff @(posedge clk) begin
    step_prev <= scan_step;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      outA          <= '0;
      direction_out <= 1'b1;
      dwell_cnt     <= '0;
      period_cnt    <= '0;
      trigger_low   <= 1'b0;
      trigger_hig   <= 1'b0;
      done          <= 1'b0;
    end else if (scan_reset) begin
      state         <= ST_IDLE;
      dwell_cnt     <= '0;
      period_cnt    <= '0;
      trigger_low   <= 1'b0;
      trigger_hig   <= 1'b0;
      done          <= 1'b0;
      outA          <= (mode == MODE_SAW_DN) ? scan_hig_lim : scan_low_lim;
      direction_out <= (mode != MODE_SAW_DN);
    end else begin
      trigger_low <= 1'b0;
      trigger_hig <= 1'b0;
      case (state)
        ST_IDLE: if (scan_enable) state <= ST_RUN;
        ST_RUN: begin
          if (scan_enable) begin
            if (step_changed) begin
              dwell_cnt <= '0;
            end else if (tick) begin
              dwell_cnt     <= '0;
              outA          <= nxt_x[R-1:0];
              direction_out <= nxt_dir;
              trigger_low   <= limits_ok && (nxt_x == lo_x) && (a_x != lo_x);
              trigger_hig   <= limits_ok && (nxt_x == hi_x) && (a_x != hi_x);
              if (period_end) begin
                if (last_period) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  period_cnt <= period_cnt + 16'd1;
                end
              end
            end else begin
              dwell_cnt <= dwell_cnt + CW'(1);
            end
          end
        end
        default: ;  // done: frozen until scan_reset or rst
      endcase
    end
  end

  gen_scan_mult #(.R(R), .BS(BS)) u_mult (
    .clk (clk),
    .rst (rst),
    .a   (outA),
    .b   (scan_B_factor),
    .p   (outB)
  );

endmodule

// File: tb/tb_gen_scan.sv
// tb_gen_scan: randomized + directed bench for gen_scan with a queue-based
// scoreboard fed by a behavioural model of the scan rules.
module tb_gen_scan;

  localparam int R  = 14;
  localparam int CW = 32;
  localparam int BS = 12;

  logic                clk;
  logic                rst;
  logic [CW-1:0]       scan_step;
  logic [R-2:0]        scan_inc;
  logic signed [R-1:0] scan_low_lim, scan_hig_lim, scan_B_factor;
  logic [1:0]          scan_mode;
  logic                scan_enable, scan_reset;
  logic [15:0]         scan_cycles;
  logic signed [R-1:0] outA, outB;
  logic                trigger_low, trigger_hig, direction_out, done;

  gen_scan #(.R(R), .CW(CW), .BS(BS)) dut (
    .clk           (clk),
    .rst           (rst),
    .scan_step     (scan_step),
    .scan_inc      (scan_inc),
    .scan_low_lim  (scan_low_lim),
    .scan_hig_lim  (scan_hig_lim),
    .scan_B_factor (scan_B_factor),
    .scan_mode     (scan_mode),
    .scan_enable   (scan_enable),
    .scan_reset    (scan_reset),
    .scan_cycles   (scan_cycles),
    .outA          (outA),
    .outB          (outB),
    .trigger_low   (trigger_low),
    .trigger_hig   (trigger_hig),
    .direction_out (direction_out),
    .done          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int a; int b; int tl; int th; int dir; int done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;   // 0 idle, 1 running, 2 finished
  int          m_a, m_dir, m_cnt, m_cyc, m_tl, m_th, m_done, m_b;
  logic [31:0] m_prev_step;
  int          m_prod_q[$];

  function automatic int scale(input int prod);
    int s;
    logic signed [R-1:0] t;
    s = prod >>> BS;
    t = s[R-1:0];
    return int'(t);
  endfunction

  function automatic int imin(input int x, input int y); return (x < y) ? x : y; endfunction
  function automatic int imax(input int x, input int y); return (x > y) ? x : y; endfunction

  // Applies the scan rules to the inputs present before a clock edge and
  // pushes the outputs expected after that edge.
  task automatic model_step();
    int lo, hi, inc, a, na, cyc_lim;
    bit changed, period;
    exp_t e;
    lo      = int'(scan_low_lim);
    hi      = int'(scan_hig_lim);
    inc     = (scan_inc == 0) ? 1 : int'(scan_inc);
    cyc_lim = int'(scan_cycles);
    a       = m_a;
    changed = (scan_step != m_prev_step);
    m_prev_step = scan_step;
    if (rst) begin
      m_state = 0; m_a = 0; m_dir = 1; m_cnt = 0; m_cyc = 0;
      m_tl = 0; m_th = 0; m_done = 0; m_b = 0;
      m_prod_q = {0};
    end else begin
      m_prod_q.push_back(a * int'(scan_B_factor));
      m_b = scale(m_prod_q.pop_front());
      m_tl = 0; m_th = 0;
      if (scan_reset) begin
        m_state = 0; m_cnt = 0; m_cyc = 0; m_done = 0;
        m_a   = (scan_mode == 2) ? hi : lo;
        m_dir = (scan_mode != 2) ? 1 : 0;
      end else if (m_state == 0) begin
        if (scan_enable) m_state = 1;
      end else if (m_state == 1 && scan_enable) begin
        if (changed) m_cnt = 0;
        else if (m_cnt != int'(scan_step)) m_cnt++;
        else begin
          m_cnt  = 0;
          period = 0;
          if (lo >= hi)    na = lo;
          else if (a < lo) na = lo;
          else if (a > hi) na = hi;
          else begin
            case (scan_mode)
              2'd0: begin
                if (m_dir == 1) begin
                  na = imin(a + inc, hi);
                  if (na == hi) m_dir = 0;
                end else begin
                  na = imax(a - inc, lo);
                  if (na == lo) begin m_dir = 1; period = (a != lo); end
                end
              end
              2'd1: begin
                m_dir = 1; period = (a == hi);
                na = (a == hi) ? lo : imin(a + inc, hi);
              end
              2'd2: begin
                m_dir = 0; period = (a == lo);
                na = (a == lo) ? hi : imax(a - inc, lo);
              end
              default: na = a;
            endcase
          end
          if (lo < hi) begin
            m_tl = (na == lo && a != lo) ? 1 : 0;
            m_th = (na == hi && a != hi) ? 1 : 0;
          end
          m_a = na;
          if (period) begin
            if (cyc_lim != 0 && m_cyc + 1 >= cyc_lim) begin m_state = 2; m_done = 1; end
            else m_cyc++;
          end
        end
      end
    end
    e.a = m_a; e.b = m_b; e.tl = m_tl; e.th = m_th; e.dir = m_dir; e.done = m_done;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("outA",          int'(outA),          e.a);
        check("outB",          int'(outB),          e.b);
        check("trigger_low",   int'(trigger_low),   e.tl);
        check("trigger_hig",   int'(trigger_hig),   e.th);
        check("direction_out", int'(direction_out), e.dir);
        check("done",          int'(done),          e.done);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic restart(input int lo, input int hi, input int inc, input int stp,
                         input int mode, input int cyc);
    scan_low_lim = R'(lo); scan_hig_lim = R'(hi); scan_inc = (R-1)'(inc);
    scan_step = CW'(stp); scan_mode = 2'(mode); scan_cycles = 16'(cyc);
    scan_enable = 1'b0; scan_reset = 1'b1;
    step();
    scan_reset = 1'b0; scan_enable = 1'b1;
    step();  // idle -> run
  endtask

  initial begin
    int ntl, nth;
    int saw_exp[5];
    rst = 1'b1; scan_step = '0; scan_inc = '0; scan_low_lim = '0; scan_hig_lim = '0;
    scan_B_factor = 14'sd4096; scan_mode = 2'd0; scan_enable = 1'b0;
    scan_reset = 1'b0; scan_cycles = '0;
    step(); step();
    check("reset_outA", int'(outA), 0);
    check("reset_dir",  int'(direction_out), 1);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    // Triangle -4..4, one tick per cycle.
    restart(-4, 4, 1, 0, 0, 0);
    ntl = 0; nth = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("tri_outA", int'(outA), (k <= 8) ? (-4 + k) : (12 - k));
      ntl += int'(trigger_low); nth += int'(trigger_hig);
    end
    check("tri_trig_low_count", ntl, 1);
    check("tri_trig_hig_count", nth, 1);

    // Saw up 0..10 step 3, tick every 2 cycles.
    saw_exp = '{3, 6, 9, 10, 0};
    restart(0, 10, 3, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("saw_hold_outA", int'(outA), (k == 0) ? 0 : saw_exp[k-1]);
      step();
      check("saw_outA", int'(outA), saw_exp[k]);
      if (k == 3) check("saw_trig_hig", int'(trigger_hig), 1);
    end

    // Two triangle periods then done.
    restart(-4, 4, 1, 0, 0, 2);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 31) check("cycles_not_done", int'(done), 0);
    end
    check("cycles_done", int'(done), 1);
    step(); step(); step();
    check("done_frozen_outA", int'(outA), -4);
    check("done_held", int'(done), 1);

    // outB scaling at full range.
    scan_low_lim = 14'sd8191; scan_hig_lim = 14'sd8191; scan_mode = 2'd1;
    scan_B_factor = 14'sd4096; scan_enable = 1'b0; scan_reset = 1'b1;
    step();
    scan_reset = 1'b0;
    step(); step();
    check("outB_pos", int'(outB), 8191);
    scan_B_factor = -14'sd4096;
    step(); step();
    check("outB_neg", int'(outB), -8191);

    // Limits moved above outA, then simultaneous scan_reset/enable.
    restart(-50, 50, 5, 0, 0, 0);
    for (int k = 0; k < 10; k++) step();
    check("lim_pre_outA", int'(outA), 0);
    scan_low_lim = 14'sd100; scan_hig_lim = 14'sd200;
    step();
    check("lim_load_outA", int'(outA), 100);
    check("lim_load_trig", int'(trigger_low), 1);
    step(); step(); step();
    scan_reset = 1'b1; scan_enable = 1'b1;
    step();
    check("sreset_outA", int'(outA), 100);
    scan_reset = 1'b0; scan_enable = 1'b0;
    step(); step();
    check("idle_outA", int'(outA), 100);
    scan_enable = 1'b1;
    step(); step();
    check("rerun_outA", int'(outA), 105);

    // Randomized operation checked only through the scoreboard.
    scan_reset = 1'b1;
    step();
    scan_reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 9) == 0) begin
          scan_low_lim = R'(int'($urandom_range(0, 16383)) - 8192);
          scan_hig_lim = R'(int'($urandom_range(0, 16383)) - 8192);
        end else begin
          scan_low_lim = R'(int'($urandom_range(0, 60)) - 40);
          scan_hig_lim = R'(int'($urandom_range(0, 60)) - 20);
        end
      end
      if ($urandom_range(0, 99) < 3) scan_step = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4) scan_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4)
        scan_inc = ($urandom_range(0, 19) == 0) ? (R-1)'($urandom_range(0, 8191))
                                                : (R-1)'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) scan_cycles = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 10) scan_B_factor = R'($urandom_range(0, 16383));
      scan_enable = ($urandom_range(0, 99) < 90);
      scan_reset  = ($urandom_range(0, 99) < 1);
      rst         = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 1'b0; scan_reset = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
